// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the ID/EX hazard controller.
package hazard_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_MEM = 2'd1,
        SEL_WB  = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    function automatic logic hit(input logic [REG_W-1:0] s,
                                 input logic [REG_W-1:0] d,
                                 input logic             en);
        return en && (d == s);
    endfunction

    // EX/MEM is the younger result, so it beats MEM/WB on a double match.
    function automatic sel_e fwd_sel(input logic             fwd_en,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] mem_dest,
                                     input logic             mem_wb_en,
                                     input logic [REG_W-1:0] wb_dest,
                                     input logic             wb_wb_en);
        if (fwd_en && hit(src, mem_dest, mem_wb_en))
            return SEL_MEM;
        else if (fwd_en && hit(src, wb_dest, wb_wb_en))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (inc && (cnt_q != {W{1'b1}}))
            cnt_q <= cnt_q + W'(1);
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX hazard control: stall/flush/freeze generation, EX forwarding selects,
// SRAM-wait timeout FSM and performance counters.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   RUN      | no SRAM wait outstanding
//   MEM_WAIT | SRAM access stalled, timer counting consecutive waits
//   ERR      | SRAM timed out; pipeline frozen until reset
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FORWARD_EN  = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_valid,
    input  logic [3:0]       exe_src1,
    input  logic [3:0]       exe_src2,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r,
    input  logic             exe_branch,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_fe,
    output logic             flush_if,
    output logic             flush_id,
    output logic             freeze_all,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int  TW     = $clog2(MEM_TIMEOUT + 1);
    localparam logic FWD_ON = (FORWARD_EN != 0);

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic          mem_err_q;

    logic raw_exe, raw_mem, raw, wait_c;

    always_comb begin
        raw_exe = hit(id_src1, exe_dest, exe_wb_en) ||
                  (id_two_src && hit(id_src2, exe_dest, exe_wb_en));
        raw_mem = hit(id_src1, mem_dest, mem_wb_en) ||
                  (id_two_src && hit(id_src2, mem_dest, mem_wb_en));
        // With forwarding only a load in EX cannot be bypassed in time.
        if (FWD_ON)
            raw = id_valid && exe_mem_r && raw_exe;
        else
            raw = id_valid && (raw_exe || raw_mem);
        wait_c = (mem_req && !mem_ready) || (state_q == ERR);
    end

    always_comb begin
        freeze_fe  = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        freeze_all = 1'b0;
        sel_src1   = SEL_RF;
        sel_src2   = SEL_RF;
        if (!rst) begin
            sel_src1 = fwd_sel(FWD_ON, exe_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
            sel_src2 = fwd_sel(FWD_ON, exe_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
            if (wait_c) begin
                freeze_all = 1'b1;
            end else if (exe_branch) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (raw) begin
                freeze_fe = 1'b1;
                flush_id  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            timer_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q <= MEM_WAIT;
                        timer_q <= TW'(1);
                    end
                end
                MEM_WAIT: begin
                    // Ready or an aborted request both end the wait.
                    if (!mem_req || mem_ready) begin
                        state_q <= RUN;
                        timer_q <= '0;
                    end else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
                        state_q   <= ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q <= RUN;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign mem_err = mem_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (freeze_fe),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_if),
        .cnt (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (freeze_all),
        .cnt (wait_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations driven in parallel,
// checked by a queue-based scoreboard against a behavioural model.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic id_two_src, id_valid, exe_wb_en, exe_mem_r, exe_branch;
    logic mem_wb_en, wb_wb_en, mem_req, mem_ready;

    logic       freeze_fe [2];
    logic       flush_if  [2];
    logic       flush_id  [2];
    logic       freeze_all[2];
    logic [1:0] sel_src1  [2];
    logic [1:0] sel_src2  [2];
    logic       mem_err   [2];
    logic [15:0] stall_a, flush_a, wait_a;
    logic [1:0]  stall_b, flush_b, wait_b;

    pipe_hazard_ctrl #(.FORWARD_EN(1), .MEM_TIMEOUT(64), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r(exe_mem_r), .exe_branch(exe_branch), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_fe(freeze_fe[0]), .flush_if(flush_if[0]), .flush_id(flush_id[0]),
        .freeze_all(freeze_all[0]), .sel_src1(sel_src1[0]), .sel_src2(sel_src2[0]),
        .mem_err(mem_err[0]), .stall_cnt(stall_a), .flush_cnt(flush_a), .wait_cnt(wait_a)
    );

    pipe_hazard_ctrl #(.FORWARD_EN(0), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_valid(id_valid),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r(exe_mem_r), .exe_branch(exe_branch), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_fe(freeze_fe[1]), .flush_if(flush_if[1]), .flush_id(flush_id[1]),
        .freeze_all(freeze_all[1]), .sel_src1(sel_src1[1]), .sel_src2(sel_src2[1]),
        .mem_err(mem_err[1]), .stall_cnt(stall_b), .flush_cnt(flush_b), .wait_cnt(wait_b)
    );

    typedef struct {
        int         cfg;
        logic [3:0] ctl;   // {freeze_fe, flush_if, flush_id, freeze_all}
        logic [1:0] s1;
        logic [1:0] s2;
        logic       err;
        int         sc;
        int         fc;
        int         wc;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_fail = 0;

    int fe_c[2]   = '{1, 0};
    int to_c[2]   = '{64, 4};
    int cmax_c[2] = '{65535, 3};
    int run_len[2], sc_m[2], fc_m[2], wc_m[2];
    bit err_m[2];

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input int c, input logic [3:0] s);
        if (fe_c[c] != 0 && mem_wb_en && s == mem_dest) return 2'd1;
        if (fe_c[c] != 0 && wb_wb_en && s == wb_dest)   return 2'd2;
        return 2'd0;
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    // Expected outputs for the cycle now being driven, then advance the model.
    task automatic push_exp();
        exp_t e;
        bit raw, w, he, hm;
        for (int c = 0; c < 2; c++) begin
            e.cfg = c;
            if (rst) begin
                e.ctl = 4'b0; e.s1 = 2'b0; e.s2 = 2'b0; e.err = 1'b0;
                e.sc = 0; e.fc = 0; e.wc = 0;
                run_len[c] = 0; err_m[c] = 0; sc_m[c] = 0; fc_m[c] = 0; wc_m[c] = 0;
            end else begin
                he  = exe_wb_en && (id_src1 == exe_dest || (id_two_src && id_src2 == exe_dest));
                hm  = mem_wb_en && (id_src1 == mem_dest || (id_two_src && id_src2 == mem_dest));
                raw = id_valid && ((fe_c[c] != 0) ? (he && exe_mem_r) : (he || hm));
                w   = (mem_req && !mem_ready) || err_m[c];
                e.ctl = w ? 4'b0001 : exe_branch ? 4'b0110 : raw ? 4'b1010 : 4'b0000;
                e.s1  = fwd(c, exe_src1);
                e.s2  = fwd(c, exe_src2);
                e.err = err_m[c];
                e.sc  = sc_m[c]; e.fc = fc_m[c]; e.wc = wc_m[c];
                if (!w && !exe_branch && raw) sc_m[c] = sat_inc(sc_m[c], cmax_c[c]);
                if (!w && exe_branch)         fc_m[c] = sat_inc(fc_m[c], cmax_c[c]);
                if (w)                        wc_m[c] = sat_inc(wc_m[c], cmax_c[c]);
                if (w && !err_m[c]) begin
                    run_len[c]++;
                    if (run_len[c] >= to_c[c]) err_m[c] = 1'b1;
                end else begin
                    run_len[c] = 0;
                end
            end
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int c;
        while (q.size() > 0) begin
            e = q.pop_front();
            c = e.cfg;
            chk($sformatf("ctl[%0d]", c),
                int'({freeze_fe[c], flush_if[c], flush_id[c], freeze_all[c]}), int'(e.ctl));
            chk($sformatf("sel_src1[%0d]", c), int'(sel_src1[c]), int'(e.s1));
            chk($sformatf("sel_src2[%0d]", c), int'(sel_src2[c]), int'(e.s2));
            chk($sformatf("mem_err[%0d]", c), int'(mem_err[c]), int'(e.err));
            chk($sformatf("stall_cnt[%0d]", c), (c == 0) ? int'(stall_a) : int'(stall_b), e.sc);
            chk($sformatf("flush_cnt[%0d]", c), (c == 0) ? int'(flush_a) : int'(flush_b), e.fc);
            chk($sformatf("wait_cnt[%0d]", c),  (c == 0) ? int'(wait_a)  : int'(wait_b),  e.wc);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_valid = 1'b0;
        exe_src1 = 4'd0; exe_src2 = 4'd0; exe_dest = 4'd0; exe_wb_en = 1'b0;
        exe_mem_r = 1'b0; exe_branch = 1'b0; mem_dest = 4'd0; mem_wb_en = 1'b0;
        wb_dest = 4'd0; wb_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic load_use();
        idle();
        id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        next(); push_exp();
        next(); push_exp();
        next(); rst = 1'b0; idle(); push_exp();

        next(); load_use(); push_exp();
        #2 chk("t1 freeze_fe", int'(freeze_fe[0]), 1);
        next(); idle(); push_exp();
        #2 chk("t1 stall_cnt", int'(stall_a), 1);

        next(); idle(); exe_src2 = 4'd5; mem_dest = 4'd5; wb_dest = 4'd5;
        mem_wb_en = 1'b1; wb_wb_en = 1'b1; push_exp();
        #2 chk("t2 sel_mem", int'(sel_src2[0]), 1);
        next(); mem_wb_en = 1'b0; push_exp();
        #2 chk("t2 sel_wb", int'(sel_src2[0]), 2);

        next(); load_use(); exe_branch = 1'b1; push_exp();
        #2 chk("t3 flush_if", int'(flush_if[0]), 1);
        chk("t3 freeze_fe", int'(freeze_fe[0]), 0);
        next(); idle(); push_exp();
        #2 chk("t3 flush_cnt", int'(flush_a), 1);

        for (int i = 0; i < 5; i++) begin
            next(); idle(); mem_req = 1'b1; push_exp();
        end
        next(); mem_req = 1'b1; mem_ready = 1'b1; push_exp();
        #2 chk("t4 ready freeze_all", int'(freeze_all[0]), 0);
        chk("t5 err freeze_all", int'(freeze_all[1]), 1);
        next(); idle(); push_exp();
        #2 chk("t4 wait_cnt", int'(wait_a), 5);
        chk("t5 mem_err", int'(mem_err[1]), 1);
        next(); rst = 1'b1; push_exp();
        #2 chk("t5 rst freeze_all", int'(freeze_all[1]), 0);
        chk("t5 rst mem_err", int'(mem_err[1]), 0);
        next(); rst = 1'b0; push_exp();

        for (int i = 0; i < 6; i++) begin
            next(); idle(); id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3;
            exe_wb_en = 1'b1; push_exp();
        end
        next(); idle(); push_exp();
        #2 chk("t6 stall sat", int'(stall_b), 3);

        for (int i = 0; i < 70; i++) begin
            next(); idle(); mem_req = 1'b1; push_exp();
        end
        #2 chk("timeout64 mem_err", int'(mem_err[0]), 1);
        next(); rst = 1'b1; idle(); push_exp();
        next(); rst = 1'b0; push_exp();

        for (int i = 0; i < 3000; i++) begin
            next();
            rst        = ($urandom_range(0, 59) == 0);
            id_src1    = 4'($urandom_range(0, 3));
            id_src2    = 4'($urandom_range(0, 3));
            id_two_src = 1'($urandom_range(0, 1));
            id_valid   = ($urandom_range(0, 9) < 8);
            exe_src1   = 4'($urandom_range(0, 3));
            exe_src2   = 4'($urandom_range(0, 3));
            exe_dest   = 4'($urandom_range(0, 3));
            exe_wb_en  = 1'($urandom_range(0, 1));
            exe_mem_r  = 1'($urandom_range(0, 1));
            exe_branch = ($urandom_range(0, 9) < 2);
            mem_dest   = 4'($urandom_range(0, 3));
            mem_wb_en  = 1'($urandom_range(0, 1));
            wb_dest    = 4'($urandom_range(0, 3));
            wb_wb_en   = 1'($urandom_range(0, 1));
            mem_req    = ($urandom_range(0, 9) < 4);
            mem_ready  = 1'($urandom_range(0, 1));
            push_exp();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
